// File: rtl/axi4lite_sys_bus_bridge.sv
// AXI4-Lite slave to sys_bus master bridge.
// Buffers AW/W/AR independently, grants one transaction at a time with
// round-robin read/write arbitration, issues single-cycle sys_bus strobes
// and bounds each sys_bus access with a saturating timeout counter.
module axi4lite_sys_bus_bridge #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    // AXI4-Lite write address
    input  logic [AW-1:0] s_awaddr,
    input  logic          s_awvalid,
    output logic          s_awready,
    // AXI4-Lite write data
    input  logic [DW-1:0] s_wdata,
    input  logic [3:0]    s_wstrb,
    input  logic          s_wvalid,
    output logic          s_wready,
    // AXI4-Lite write response
    output logic [1:0]    s_bresp,
    output logic          s_bvalid,
    input  logic          s_bready,
    // AXI4-Lite read address
    input  logic [AW-1:0] s_araddr,
    input  logic          s_arvalid,
    output logic          s_arready,
    // AXI4-Lite read data
    output logic [DW-1:0] s_rdata,
    output logic [1:0]    s_rresp,
    output logic          s_rvalid,
    input  logic          s_rready,
    // sys_bus master
    output logic [AW-1:0] sys_addr,
    output logic [DW-1:0] sys_wdata,
    output logic          sys_wen,
    output logic          sys_ren,
    input  logic [DW-1:0] sys_rdata,
    input  logic          sys_err,
    input  logic          sys_ack
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_STB, WR_WAIT, RD_STB, RD_WAIT, B_RESP, R_RESP
    } state_t;

    state_t        state, next_state;

    logic          aw_full, w_full, ar_full;
    logic [AW-1:0] aw_addr, ar_addr;
    logic [DW-1:0] w_data;
    logic [3:0]    w_strb;

    logic          prefer_wr;
    logic [CW-1:0] cnt;
    logic          resp_err;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic          wr_pend, rd_pend, grant_wr, grant_rd;
    logic          cnt_done, b_done, r_done, full_strb;

    assign wr_pend   = aw_full & w_full;
    assign rd_pend   = ar_full;
    assign full_strb = (w_strb == 4'hF);
    assign cnt_done  = (cnt == CW'(TIMEOUT));
    assign b_done    = (state == B_RESP) && s_bready;
    assign r_done    = (state == R_RESP) && s_rready;

    assign s_awready = ~aw_full;
    assign s_wready  = ~w_full;
    assign s_arready = ~ar_full;

    assign sys_wen   = (state == WR_STB);
    assign sys_ren   = (state == RD_STB);
    assign sys_addr  = addr_q;
    assign sys_wdata = wdata_q;

    assign s_bvalid  = (state == B_RESP);
    assign s_bresp   = {s_bvalid & resp_err, 1'b0};
    assign s_rvalid  = (state == R_RESP);
    assign s_rresp   = {s_rvalid & resp_err, 1'b0};
    assign s_rdata   = rdata_q;

    // Channel buffers: fill on handshake, drain only when the response is accepted
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            ar_full <= 1'b0;
            aw_addr <= '0;
            ar_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (s_awvalid && !aw_full) begin
                aw_full <= 1'b1;
                aw_addr <= s_awaddr;
            end else if (b_done) begin
                aw_full <= 1'b0;
            end
            if (s_wvalid && !w_full) begin
                w_full <= 1'b1;
                w_data <= s_wdata;
                w_strb <= s_wstrb;
            end else if (b_done) begin
                w_full <= 1'b0;
            end
            if (s_arvalid && !ar_full) begin
                ar_full <= 1'b1;
                ar_addr <= s_araddr;
            end else if (r_done) begin
                ar_full <= 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic and round-robin grant
    always_comb begin
        next_state = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend && (!rd_pend || prefer_wr)) begin
                    grant_wr   = 1'b1;
                    next_state = full_strb ? WR_STB : B_RESP;
                end else if (rd_pend) begin
                    grant_rd   = 1'b1;
                    next_state = RD_STB;
                end
            end
            WR_STB:  next_state = sys_ack ? B_RESP : WR_WAIT;
            WR_WAIT: if (sys_ack || cnt_done) next_state = B_RESP;
            RD_STB:  next_state = sys_ack ? R_RESP : RD_WAIT;
            RD_WAIT: if (sys_ack || cnt_done) next_state = R_RESP;
            B_RESP:  if (s_bready) next_state = IDLE;
            R_RESP:  if (s_rready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // sys_bus address/data, arbitration pointer, timeout counter and response capture
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prefer_wr <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            resp_err  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (grant_wr) begin
                prefer_wr <= 1'b0;
                resp_err  <= ~full_strb;
                if (full_strb) begin
                    addr_q  <= aw_addr;
                    wdata_q <= w_data;
                end
            end
            if (grant_rd) begin
                prefer_wr <= 1'b1;
                addr_q    <= ar_addr;
            end
            case (state)
                WR_STB, RD_STB: begin
                    cnt <= '0;
                    if (sys_ack) begin
                        resp_err <= sys_err;
                        if (state == RD_STB) rdata_q <= sys_rdata;
                    end
                end
                WR_WAIT, RD_WAIT: begin
                    if (sys_ack) begin
                        resp_err <= sys_err;
                        if (state == RD_WAIT) rdata_q <= sys_rdata;
                    end else if (cnt_done) begin
                        resp_err <= 1'b1;
                        if (state == RD_WAIT) rdata_q <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_sys_bus_bridge.sv
// Directed self-checking bench for axi4lite_sys_bus_bridge.
module tb_axi4lite_sys_bus_bridge;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;

    logic [31:0] s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid, s_rready;
    logic [31:0] sys_addr, sys_wdata, sys_rdata;
    logic        sys_wen, sys_ren, sys_err, sys_ack;

    int          total = 0;
    int          bad   = 0;

    int          wen_cnt = 0;
    int          ren_cnt = 0;
    logic [31:0] mon_addr  = '0;
    logic [31:0] mon_wdata = '0;
    int          grants[$];

    bit          slv_enable = 1'b1;
    int          slv_delay  = 1;
    logic        slv_err    = 1'b0;
    logic [31:0] slv_rdata  = '0;
    bit          spur_ack   = 1'b0;
    int          ack_wait   = 0;

    always #5 clk = ~clk;

    axi4lite_sys_bus_bridge #(.AW(32), .DW(32), .TIMEOUT(255)) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_err   (sys_err),
        .sys_ack   (sys_ack)
    );

    // sys_bus slave model: logs strobes, answers slv_delay cycles after a strobe
    always @(negedge clk) begin
        sys_ack   = 1'b0;
        sys_err   = 1'b0;
        sys_rdata = '0;
        if (!rstn) ack_wait = 0;
        if (spur_ack) begin
            sys_ack   = 1'b1;
            sys_err   = 1'b1;
            sys_rdata = 32'hBAD0BAD0;
            spur_ack  = 1'b0;
        end
        if (sys_wen || sys_ren) begin
            mon_addr = sys_addr;
            if (sys_wen) begin
                wen_cnt++;
                mon_wdata = sys_wdata;
                grants.push_back(1);
            end else begin
                ren_cnt++;
                grants.push_back(0);
            end
            ack_wait = slv_enable ? slv_delay : 0;
        end else if (ack_wait > 0) begin
            ack_wait--;
            if (ack_wait == 0) begin
                sys_ack   = 1'b1;
                sys_err   = slv_err;
                sys_rdata = slv_rdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic post(input bit do_aw, input bit do_w, input bit do_ar,
                        input logic [31:0] aw, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] ar);
        @(negedge clk);
        s_awvalid = do_aw;
        s_awaddr  = aw;
        s_wvalid  = do_w;
        s_wdata   = wd;
        s_wstrb   = st;
        s_arvalid = do_ar;
        s_araddr  = ar;
        @(posedge clk);
        #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
    endtask

    task automatic wait_b(input string tag, input logic [1:0] exp_resp, input int hold);
        int n = 0;
        @(negedge clk);
        while (!s_bvalid && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(s_bresp), 32'(exp_resp));
        if (hold > 0) begin
            cyc(hold);
            chk({tag, "_bvalid_hold"}, 32'(s_bvalid), 32'd1);
            chk({tag, "_bresp_hold"}, 32'(s_bresp), 32'(exp_resp));
        end
        s_bready = 1'b1;
        @(posedge clk);
        #1;
        s_bready = 1'b0;
    endtask

    task automatic wait_r(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n = 0;
        @(negedge clk);
        while (!s_rvalid && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
        chk({tag, "_rresp"}, 32'(s_rresp), 32'(exp_resp));
        chk({tag, "_rdata"}, s_rdata, exp_data);
        s_rready = 1'b1;
        @(posedge clk);
        #1;
        s_rready = 1'b0;
    endtask

    task automatic finish_any(input string tag);
        int n = 0;
        @(negedge clk);
        while (!s_bvalid && !s_rvalid && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(s_bvalid | s_rvalid), 32'd1);
        if (s_bvalid) begin
            chk({tag, "_bresp"}, 32'(s_bresp), 32'd0);
            s_bready = 1'b1;
        end else begin
            chk({tag, "_rresp"}, 32'(s_rresp), 32'd0);
            chk({tag, "_rdata"}, s_rdata, slv_rdata);
            s_rready = 1'b1;
        end
        @(posedge clk);
        #1;
        s_bready = 1'b0;
        s_rready = 1'b0;
    endtask

    initial begin
        int ren0;
        int g0;
        int g1;
        bit seen_rv;

        s_awaddr = '0; s_awvalid = 1'b0;
        s_wdata  = '0; s_wstrb   = '0; s_wvalid = 1'b0;
        s_bready = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_awready", 32'(s_awready), 32'd1);
        chk("rst_wready",  32'(s_wready),  32'd1);
        chk("rst_arready", 32'(s_arready), 32'd1);
        chk("rst_bvalid",  32'(s_bvalid),  32'd0);
        chk("rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("rst_wen",     32'(sys_wen),   32'd0);
        chk("rst_ren",     32'(sys_ren),   32'd0);
        chk("rst_addr",    sys_addr,       32'd0);
        chk("rst_rdata",   s_rdata,        32'd0);
        rstn = 1'b1;

        // 1: AW and W together, ack one cycle after wen
        slv_delay = 1;
        slv_err   = 1'b0;
        post(1, 1, 0, 32'h40000010, 32'hDEADBEEF, 4'hF, 32'h0);
        @(negedge clk);
        chk("t1_no_early_wen", 32'(sys_wen), 32'd0);
        @(negedge clk);
        chk("t1_wen",          32'(sys_wen), 32'd1);
        chk("t1_sys_addr",     sys_addr,     32'h40000010);
        chk("t1_sys_wdata",    sys_wdata,    32'hDEADBEEF);
        chk("t1_awready_busy", 32'(s_awready), 32'd0);
        chk("t1_wready_busy",  32'(s_wready),  32'd0);
        wait_b("t1", 2'b00, 2);
        @(negedge clk);
        chk("t1_awready_back", 32'(s_awready), 32'd1);
        chk("t1_wready_back",  32'(s_wready),  32'd1);
        chk("t1_wen_count",    32'(wen_cnt),   32'd1);
        chk("t1_mon_addr",     mon_addr,       32'h40000010);
        chk("t1_mon_wdata",    mon_wdata,      32'hDEADBEEF);

        // 2: read, ack three cycles after ren
        slv_delay = 3;
        slv_rdata = 32'h12345678;
        post(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h40100004);
        wait_r("t2", 32'h12345678, 2'b00);
        chk("t2_ren_count", 32'(ren_cnt), 32'd1);
        chk("t2_wen_count", 32'(wen_cnt), 32'd1);
        chk("t2_mon_addr",  mon_addr,     32'h40100004);

        // 3: W five cycles before AW, then a partial-strobe write
        slv_delay = 1;
        post(0, 1, 0, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0);
        cyc(5);
        chk("t3_no_wen_w_only", 32'(wen_cnt),   32'd1);
        chk("t3_wready_full",   32'(s_wready),  32'd0);
        chk("t3_awready_empty", 32'(s_awready), 32'd1);
        chk("t3_no_bvalid",     32'(s_bvalid),  32'd0);
        post(1, 0, 0, 32'h40000020, 32'h0, 4'h0, 32'h0);
        wait_b("t3a", 2'b00, 0);
        chk("t3a_wen_count", 32'(wen_cnt), 32'd2);
        chk("t3a_mon_addr",  mon_addr,     32'h40000020);
        chk("t3a_mon_wdata", mon_wdata,    32'hCAFEF00D);
        post(1, 1, 0, 32'h40000030, 32'h11111111, 4'h3, 32'h0);
        wait_b("t3b", 2'b10, 0);
        chk("t3b_no_wen", 32'(wen_cnt), 32'd2);

        // 4: simultaneous read+write; lone transactions steer the pointer between rounds
        @(negedge clk);
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        slv_delay = 1;
        slv_rdata = 32'h55AA0001;
        for (int r = 0; r < 4; r++) begin
            if (r == 1 || r == 3) begin
                post(1, 1, 0, 32'h40000100, 32'h00000100 + 32'(r), 4'hF, 32'h0);
                wait_b("t4_lone_wr", 2'b00, 0);
            end else if (r == 2) begin
                post(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h40000104);
                wait_r("t4_lone_rd", 32'h55AA0001, 2'b00);
            end
            grants.delete();
            post(1, 1, 1, 32'h40000200, 32'h00001000 + 32'(r), 4'hF, 32'h40000300);
            finish_any("t4_first");
            finish_any("t4_second");
            g0 = (grants.size() > 0) ? grants[0] : 9;
            g1 = (grants.size() > 1) ? grants[1] : 9;
            chk($sformatf("t4_round%0d_first_grant", r),  32'(g0), (r % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t4_round%0d_second_grant", r), 32'(g1), (r % 2 == 0) ? 32'd0 : 32'd1);
        end

        // 5: timeout on a read, spurious acks afterwards are ignored
        slv_enable = 1'b0;
        ren0 = ren_cnt;
        post(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h40200008);
        cyc(200);
        chk("t5_not_early", 32'(s_rvalid), 32'd0);
        for (int n = 0; n < 200 && !s_rvalid; n++) @(negedge clk);
        chk("t5_rvalid",  32'(s_rvalid), 32'd1);
        chk("t5_rresp",   32'(s_rresp),  32'd2);
        chk("t5_rdata",   s_rdata,       32'd0);
        spur_ack = 1'b1;
        cyc(2);
        chk("t5_hold_rvalid", 32'(s_rvalid), 32'd1);
        chk("t5_hold_rresp",  32'(s_rresp),  32'd2);
        chk("t5_hold_rdata",  s_rdata,       32'd0);
        s_rready = 1'b1;
        @(posedge clk);
        #1;
        s_rready = 1'b0;
        spur_ack = 1'b1;
        cyc(3);
        chk("t5_spur_idle_bvalid", 32'(s_bvalid), 32'd0);
        chk("t5_spur_idle_rvalid", 32'(s_rvalid), 32'd0);
        slv_enable = 1'b1;
        slv_delay  = 2;
        slv_rdata  = 32'hA5A55A5A;
        post(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h40200010);
        wait_r("t5_next", 32'hA5A55A5A, 2'b00);
        chk("t5_ren_count", 32'(ren_cnt), 32'(ren0 + 2));

        // 6: slave error on a write, then reset during RD_WAIT
        slv_err   = 1'b1;
        slv_delay = 1;
        post(1, 1, 0, 32'h40000400, 32'h0F0F0F0F, 4'hF, 32'h0);
        wait_b("t6_err", 2'b10, 0);
        slv_err    = 1'b0;
        slv_enable = 1'b0;
        post(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h40300000);
        cyc(5);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_arready", 32'(s_arready), 32'd1);
        chk("t6_rst_awready", 32'(s_awready), 32'd1);
        chk("t6_rst_wready",  32'(s_wready),  32'd1);
        chk("t6_rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("t6_rst_bvalid",  32'(s_bvalid),  32'd0);
        chk("t6_rst_ren",     32'(sys_ren),   32'd0);
        chk("t6_rst_addr",    sys_addr,       32'd0);
        chk("t6_rst_rdata",   s_rdata,        32'd0);
        cyc(2);
        rstn = 1'b1;
        ren0 = ren_cnt;
        seen_rv = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_rvalid) seen_rv = 1'b1;
        end
        chk("t6_no_response", 32'(seen_rv), 32'd0);
        chk("t6_no_strobe",   32'(ren_cnt), 32'(ren0));
        slv_enable = 1'b1;
        slv_rdata  = 32'h0BADCAFE;
        post(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h40300004);
        wait_r("t6_after", 32'h0BADCAFE, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4lite_sys_bus_bridge.md
Name: axi4lite_sys_bus_bridge

Overview:
- AXI4-Lite slave to sys_bus master bridge. Sits directly upstream of the system bus interconnect and drives its master port (addr/wdata/wen/ren in; rdata/ack/err back).
- Handles one transaction at a time.
- Arbitrates between reads and writes round-robin.
- Generates single-cycle wen/ren strobes.
- Guards against non-responding slaves with a timeout counter.

Parameters:
AW, 32, address width (AXI and sys_bus)
DW, 32, data width (fixed 32; WSTRB is 4 bits)
TIMEOUT, 255, cycles to wait for sys_ack after strobe before forcing an error response (>=2)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  synchronous active-low reset
s_awaddr  in  AW  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  AW  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read valid
s_rready  in  1  read ready
sys_addr  out  AW  sys_bus address
sys_wdata  out  32  sys_bus write data
sys_wen  out  1  write strobe, one cycle
sys_ren  out  1  read strobe, one cycle
sys_rdata  in  32  read data, valid with sys_ack
sys_err  in  1  slave error, valid with sys_ack
sys_ack  in  1  slave acknowledge

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-low on rstn_i, sampled on the rising clk_i edge.
- Reset values: all outputs 0, except s_awready=1, s_wready=1 and s_arready=1. FSM goes to IDLE; buffers are empty; arbitration pointer prefers write.
- AW buffer: s_awready = AW buffer empty. Capture on s_awvalid&s_awready.
- W buffer: s_wready = W buffer empty. Capture on s_wvalid&s_wready. AW and W are independent, either order, including the same cycle.
- AR buffer: s_arready = AR buffer empty. Capture on s_arvalid&s_arready.
- Write pending = AW and W buffers both full. Read pending = AR buffer full.
- FSM states: IDLE, WR_STB, WR_WAIT, RD_STB, RD_WAIT, B_RESP, R_RESP.
- IDLE arbitration:
  - Only write pending -> WR_STB.
  - Only read pending -> RD_STB.
  - Both pending -> the pointer decides. The pointer toggles to the other type after each granted transaction.
  - Grant decision is registered: the strobe appears the cycle after both buffers are full, at the earliest.
- Partial strobes: a write with s_wstrb != 4'hF issues no sys_bus access. It goes IDLE -> B_RESP with SLVERR.
- WR_STB:
  - sys_wen=1 for exactly one cycle.
  - sys_addr/sys_wdata come from the buffers; they are held stable from WR_STB until leaving WR_WAIT.
  - The timeout counter loads 0.
  - Next state is WR_WAIT. If sys_ack is already high during WR_STB, go directly to B_RESP.
- RD_STB / RD_WAIT: identical to WR_STB / WR_WAIT, using sys_ren. sys_wdata is don't-care, held at its last value.
- WR_WAIT / RD_WAIT:
  - sys_ack sampled high -> capture sys_err (and sys_rdata for reads). Go to B_RESP / R_RESP.
  - Counter reaches TIMEOUT with no ack -> SLVERR; for reads s_rdata=0.
  - Counter width is $clog2(TIMEOUT+1) and it saturates; it never wraps.
- B_RESP:
  - s_bvalid=1, s_bresp = err ? 2'b10 : 2'b00.
  - Held until s_bready. On the handshake, clear the AW and W buffers and return to IDLE.
- R_RESP:
  - s_rvalid=1, s_rdata and s_rresp registered.
  - Held until s_rready. On the handshake, clear the AR buffer and return to IDLE.
- Response outputs are stable while valid and unaccepted. A late sys_ack arriving outside WAIT states is ignored.
- Buffers may refill while a transaction of the other type is in flight. A buffer cannot be overwritten until its transaction completes.
- Reset mid-transaction: everything returns to reset values on the next edge. No strobe is issued after reset. An in-flight response is dropped.

Test Plan:
1. Write: AW 0x40000010 and W 0xDEADBEEF in the same cycle; slave acks 1 cycle after wen -> exactly one sys_wen pulse with addr 0x40000010 / data 0xDEADBEEF; s_bvalid with BRESP=00; awready/wready re-assert after bready.
2. Read: AR 0x40100004; slave returns rdata 0x12345678 with ack 3 cycles after ren -> s_rdata=0x12345678, RRESP=00; exactly one sys_ren pulse.
3. W before AW by 5 cycles; plus wstrb=4'h3 case -> with full strobes, the strobe occurs only after AW arrives; with wstrb=4'h3, no sys_wen is issued and BRESP=10.
4. Simultaneous pending read and write, repeated 4 times -> grants alternate W,R,W,R starting with write after reset.
5. Timeout: ack never asserted, TIMEOUT=255 -> RRESP=10, s_rdata=0 after the counter reaches 255; a later spurious ack is ignored and the next transaction proceeds normally.
6. Error and reset: slave asserts err with ack -> BRESP=10. Separately, assert rstn_i low during RD_WAIT -> all outputs return to reset values on the next edge and no response is produced.
